// File: rtl/instr_mem_pipe.sv
// Pipelined, cell-addressed instruction memory.
// Cells are CELL_W bits wide; CELLS_PER_INSTR consecutive cells form one instruction, with the
// MSB cell at the lowest address. Provides a program-load port, a hardware clear sweep after
// reset, and a registered fetch port with stall/hold.
// Optional feature: define IMEM_ALIGN_CHECK_EN to flag misaligned fetches on fetch_err and
// return a NOP for them.
module instr_mem_pipe #(
    parameter int unsigned CELL_W          = 4,
    parameter int unsigned CELLS_PER_INSTR = 4,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned ADDR_W          = 16,
    localparam int unsigned IW             = CELL_W * CELLS_PER_INSTR,
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CELL_W-1:0] load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_valid,
    output logic [IW-1:0]     instruction,
    output logic              fetch_err,
    output logic              busy
);

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [CELL_W-1:0] mem [DEPTH];
    logic [IW-1:0]     fetch_word;
    logic              fetch_misaligned;
    logic              run;
    logic              load_fire;
    logic              fetch_fire;

    // Address bits above the memory index are ignored (addresses wrap modulo DEPTH).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[ADDR_W-1:AW], fetch_addr[ADDR_W-1:AW]};

    assign run        = rst && (state_q == StRun);
    assign load_ready = run;
    assign busy       = !run;
    assign load_fire  = load_valid && run;
    assign fetch_fire = run && !fetch_stall;

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: sweep every cell once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StClear;
        endcase
    end

    // Cell writes: zero fill during clear, program loads in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == StClear) begin
                mem[clr_ptr_q] <= '0;
            end else if (load_fire) begin
                mem[load_addr[AW-1:0]] <= load_data;
            end
        end
    end

    // Gather the instruction's cells, wrapping past the top of memory. Reading here, ahead of
    // the write edge, gives read-before-write on a same-edge load collision.
    always_comb begin
        fetch_word = '0;
        for (int k = 0; k < int'(CELLS_PER_INSTR); k++) begin
            fetch_word[IW-1-k*CELL_W -: CELL_W] = mem[fetch_addr[AW-1:0] + AW'(k)];
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    assign fetch_misaligned = (fetch_addr % ADDR_W'(CELLS_PER_INSTR)) != '0;
`else
    assign fetch_misaligned = 1'b0;
`endif

    // Fetch output register: updates only when not stalled; instruction holds when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_valid <= 1'b0;
            instruction <= '0;
            fetch_err   <= 1'b0;
        end else if (fetch_fire) begin
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                instruction <= fetch_misaligned ? '0 : fetch_word;
                fetch_err   <= fetch_misaligned;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed testbench for instr_mem_pipe (default parameters). Honours IMEM_ALIGN_CHECK_EN.
module tb_instr_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_addr;
    logic [3:0]  load_data;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_valid;
    logic [15:0] instruction;
    logic        fetch_err;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    instr_mem_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .instruction (instruction),
        .fetch_err   (fetch_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [3:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    // Count busy cycles after reset release, with fetch requests offered throughout.
    task automatic count_clear(input string tag);
        int n = 0;
        logic saw_ready = 1'b0;
        logic saw_valid = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        while (busy && n < 200) begin
            saw_ready |= load_ready;
            saw_valid |= fetch_valid;
            n++;
            tick();
        end
        fetch_req = 1'b0;
        chk({tag, "_busy_cycles"}, n, 64);
        chk({tag, "_ready_in_clear"}, {31'd0, saw_ready}, 0);
        chk({tag, "_valid_in_clear"}, {31'd0, saw_valid}, 0);
        chk({tag, "_ready_after"}, {31'd0, load_ready}, 1);
    endtask

    initial begin
        rst         = 1'b0;
        load_valid  = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_ready", {31'd0, load_ready}, 0);
        chk("rst_valid", {31'd0, fetch_valid}, 0);
        chk("rst_instr", {16'd0, instruction}, 0);
        chk("rst_err", {31'd0, fetch_err}, 0);

        rst = 1'b1;
        count_clear("clr1");

        // Cleared memory reads zero.
        fetch(16'd8);
        chk("clr_fetch_valid", {31'd0, fetch_valid}, 1);
        chk("clr_fetch_instr", {16'd0, instruction}, 32'h0000);

        // Program load.
        load(16'd8, 4'h3);  load(16'd9, 4'h7);  load(16'd10, 4'h0); load(16'd11, 4'h9);
        load(16'd12, 4'h3); load(16'd13, 4'h0); load(16'd14, 4'h0); load(16'd15, 4'hF);

        // Back-to-back fetches.
        fetch_req  = 1'b1;
        fetch_addr = 16'd8;
        tick();
        chk("f8_valid", {31'd0, fetch_valid}, 1);
        chk("f8_instr", {16'd0, instruction}, 32'h3709);
        fetch_addr = 16'd12;
        tick();
        chk("f12_instr", {16'd0, instruction}, 32'h300F);
        chk("f12_err", {31'd0, fetch_err}, 0);
        fetch_req = 1'b0;
        tick();
        chk("idle_valid", {31'd0, fetch_valid}, 0);
        chk("idle_hold", {16'd0, instruction}, 32'h300F);

        // Stall holds outputs and drops requests.
        fetch(16'd8);
        chk("pre_stall", {16'd0, instruction}, 32'h3709);
        fetch_stall = 1'b1;
        fetch_req   = 1'b1;
        fetch_addr  = 16'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", {16'd0, instruction}, 32'h3709);
            chk("stall_valid", {31'd0, fetch_valid}, 1);
        end
        fetch_stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        chk("post_stall", {16'd0, instruction}, 32'h300F);

        // Same-edge load and fetch: old data returned, new data next cycle.
        load(16'd20, 4'h0); load(16'd21, 4'h3); load(16'd22, 4'h1); load(16'd23, 4'h0);
        load_valid = 1'b1;
        load_addr  = 16'd21;
        load_data  = 4'hF;
        fetch_req  = 1'b1;
        fetch_addr = 16'd20;
        tick();
        load_valid = 1'b0;
        chk("coll_old", {16'd0, instruction}, 32'h0310);
        tick();
        fetch_req = 1'b0;
        chk("coll_new", {16'd0, instruction}, 32'h0F10);

        // Address bits above the index are ignored: 0x45 maps to cell 5, 0x44 to cell 4.
        load(16'h0045, 4'h5);
        fetch(16'h0044);
        chk("mod_instr", {16'd0, instruction}, 32'h0500);

        // Wrap across the top of memory.
        load(16'd62, 4'hA); load(16'd63, 4'hB); load(16'd0, 4'hC); load(16'd1, 4'hD);
        fetch(16'd62);
        chk("wrap_valid", {31'd0, fetch_valid}, 1);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("wrap_instr", {16'd0, instruction}, 32'h0000);
        chk("wrap_err", {31'd0, fetch_err}, 1);
        fetch(16'd8);
        chk("align_err_clr", {31'd0, fetch_err}, 0);
`else
        chk("wrap_instr", {16'd0, instruction}, 32'hABCD);
        chk("wrap_err", {31'd0, fetch_err}, 0);
`endif

        // Reset in the middle of a load beat.
        load_valid = 1'b1;
        load_addr  = 16'd8;
        load_data  = 4'hE;
        rst        = 1'b0;
        tick();
        chk("midload_ready", {31'd0, load_ready}, 0);
        chk("midload_busy", {31'd0, busy}, 1);
        chk("midload_valid", {31'd0, fetch_valid}, 0);
        chk("midload_instr", {16'd0, instruction}, 0);
        load_valid = 1'b0;
        rst        = 1'b1;

        // Reset again partway through the clear sweep; the sweep restarts in full.
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        count_clear("clr2");
        fetch(16'd8);
        chk("reclr_f8", {16'd0, instruction}, 32'h0000);
        fetch(16'd20);
        chk("reclr_f20", {16'd0, instruction}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
